capture_fifo_param: RTL and testbench

//  Parametrised single-clock ADC sample buffer for the AD9284 capture path; successor of the fixed 64k x 16 store.
//  - Sits between the deserialised LVDS sample stream and the host readout logic.
//  - Configurable width and depth, with occupancy count and almost-full threshold.
//  - Sticky overflow/underflow flags and a snapshot mode: arm, fill once, stop.

---
 rtl/capture_fifo_param.sv | 179 +++++++++++++++++
 tb/tb_capture_fifo_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/capture_fifo_param.sv
// capture_fifo_param: parametrised single-clock ADC sample buffer.
// The write request and data are registered for one cycle before they reach
// memory. Occupancy is tracked in a counter. Overflow and underflow flags are
// sticky. A snapshot FSM (arm, fill once, stop) is active when mode=1.
// Optional macro FIFO_FWFT_EN selects first-word-fall-through reads; the
// default is a standard registered read.
module capture_fifo_param #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int AF_THRESH = 768
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [DATA_W-1:0] din,
  input  logic              rden,
  output logic [DATA_W-1:0] data_out,
  output logic              dout_valid,
  input  logic              mode,
  input  logic              arm,
  input  logic              clr_flags,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic              done
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_DONE} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wen_q;
  logic [DATA_W-1:0] din_q;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, empty_q, af_q;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              mode_q;
  state_t            state_q, state_d;

  logic wr_allow, wr_req, commit, pop, ovf_err, unf_err;

  // Input stage: register the write request and sample word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q <= 1'b0;
      din_q <= '0;
    end else begin
      wen_q <= wen;
      din_q <= din;
    end
  end

  // Commit/pop decisions, occupancy, pointers and sticky error flags.
  always_comb begin
    wr_allow = !mode || (state_q == S_CAPT);
    pop      = rden && !empty_q;
    wr_req   = wen_q && wr_allow;
    commit   = wr_req && (!full_q || pop);
    ovf_err  = wr_req && !commit;
    unf_err  = rden && empty_q;
    wr_ptr_d = commit ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (commit && !pop)      count_d = count_q + CNT_ONE;
    else if (!commit && pop) count_d = count_q - CNT_ONE;
    ovf_d = (ovf_q && !clr_flags) || ovf_err;
    unf_d = (unf_q && !clr_flags) || unf_err;
  end

  // FIFO state registers; status flags follow the next count on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      af_q     <= (count_d >= AF_C);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Sample storage; no reset needed, occupancy guards every read.
  always_ff @(posedge clk) begin
    if (commit) mem[wr_ptr_q] <= din_q;
  end

  // Snapshot FSM next state; any mode change or continuous mode forces IDLE.
  always_comb begin
    state_d = state_q;
    if (!mode || (mode != mode_q)) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (arm) state_d = S_CAPT;
        S_CAPT:  if (count_d == DEPTH_C) state_d = S_DONE;
        S_DONE:  if (arm) state_d = S_CAPT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Snapshot FSM state register and previous mode for change detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented combinationally whenever the FIFO holds data.
  always_comb begin
    data_out   = empty_q ? '0 : mem[rd_ptr_q];
    dout_valid = !empty_q;
  end
`else
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dvalid_q;

  // Standard read: the popped word is loaded next edge, held otherwise.
  always_comb begin
    dout_d = pop ? mem[rd_ptr_q] : dout_q;
  end

  // Read data register and one-cycle valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      dvalid_q <= pop;
    end
  end

  // Drive read outputs from the registered read stage.
  always_comb begin
    data_out   = dout_q;
    dout_valid = dvalid_q;
  end
`endif

  // Status outputs.
  always_comb begin
    full        = full_q;
    empty       = empty_q;
    almost_full = af_q;
    count       = count_q;
    overflow    = ovf_q;
    underflow   = unf_q;
    done        = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_capture_fifo_param.sv
// Testbench for capture_fifo_param (DATA_W=16, ADDR_W=4, AF_THRESH=12).
// The reference model is a word queue plus a one-deep input-stage latch.
// Status outputs are compared after every edge. Read data is checked by a
// separate negedge monitor that pops expected words from a scoreboard queue.
module tb_capture_fifo_param;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AF = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          wen, rden, mode, arm, clr_flags;
  logic [DW-1:0] din;
  logic [DW-1:0] data_out;
  logic          dout_valid, full, empty, almost_full, overflow, underflow, done;
  logic [AW:0]   count;

  capture_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AF_THRESH(AF)) dut (
    .clk(clk), .rst(rst), .wen(wen), .din(din), .rden(rden),
    .data_out(data_out), .dout_valid(dout_valid), .mode(mode), .arm(arm),
    .clr_flags(clr_flags), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .overflow(overflow),
    .underflow(underflow), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_last;
  bit            m_pv;
  logic [DW-1:0] m_pd;
  bit            m_ovf, m_unf, m_capt, m_done, m_pmode;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_last = '0;
    m_pv = 0; m_pd = '0;
    m_ovf = 0; m_unf = 0; m_capt = 0; m_done = 0; m_pmode = 0;
  endtask

  task automatic check_status();
    chk("count", int'(count), mq.size());
    chk("empty", int'(empty), int'(mq.size() == 0));
    chk("full", int'(full), int'(mq.size() == DEPTH));
    chk("almost_full", int'(almost_full), int'(mq.size() >= AF));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_unf));
    chk("done", int'(done), int'(m_done));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wen = 0; rden = 0; arm = 0; clr_flags = 0; mode = 0; din = '0;
    #1;
    model_reset();
    check_status();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock cycle with the given inputs, then advance the model and compare.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r,
                      input bit m, input bit a, input bit c);
    bit pop, unf_e, ovf_e, allowed;
    logic [DW-1:0] popped;
    wen = w; din = d; rden = r; mode = m; arm = a; clr_flags = c;
    @(posedge clk); #1;
    pop     = r && (mq.size() > 0);
    unf_e   = r && (mq.size() == 0);
    allowed = !m || m_capt;
    ovf_e   = 0;
    if (pop) begin
      popped = mq.pop_front();
`ifndef FIFO_FWFT_EN
      exp_q.push_back(popped);
`endif
    end
    if (m_pv && allowed) begin
      if (mq.size() < DEPTH) mq.push_back(m_pd);
      else ovf_e = 1;
    end
    m_ovf = (m_ovf && !c) || ovf_e;
    m_unf = (m_unf && !c) || unf_e;
    if (!m || (m != m_pmode)) begin
      m_capt = 0; m_done = 0;
    end else if (m_capt) begin
      if (mq.size() == DEPTH) begin m_capt = 0; m_done = 1; end
    end else if (a) begin
      m_capt = 1; m_done = 0;
    end
    m_pv = w; m_pd = d; m_pmode = m;
    check_status();
  endtask

  task automatic idle(input int n, input bit m);
    for (int i = 0; i < n; i++) step(0, '0, 0, m, 0, 0);
  endtask

  // Read-data monitor, decoupled from stimulus.
  always @(negedge clk) begin
    if (!rst) begin
`ifdef FIFO_FWFT_EN
      chk("dout_valid", int'(dout_valid), int'(mq.size() != 0));
      if (mq.size() != 0) chk("data_out_head", int'(data_out), int'(mq[0]));
`else
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_dout_valid", 1, 0);
        end else begin
          m_last = exp_q.pop_front();
          chk("data_out", int'(data_out), int'(m_last));
        end
      end else begin
        chk("data_out_hold", int'(data_out), int'(m_last));
      end
`endif
    end
  end

  initial begin
    do_reset();

    // Async reset mid-run with five words stored
    for (int i = 0; i < 5; i++) step(1, DW'(16'h0050 + i), 0, 0, 0, 0);
    idle(2, 0);
    chk("count_before_reset", int'(count), 5);
    do_reset();

    // Continuous fill past full, then drain in order
    for (int i = 0; i <= 16; i++) step(1, DW'(i), 0, 0, 0, 0);
    idle(2, 0);
    chk("overflow_after_17", int'(overflow), 1);
    for (int i = 0; i < 16; i++) step(0, '0, 1, 0, 0, 0);
    idle(2, 0);

    // Clear flags, refill to full, then simultaneous write+pop at full
    step(0, '0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, DW'(16'h0200 + i), 0, 0, 0, 0);
    idle(2, 0);
    for (int i = 0; i < 8; i++) step(1, DW'(16'h0300 + i), 1, 0, 0, 0);
    idle(2, 0);
    chk("full_after_rw", int'(count), 16);
    for (int i = 0; i < 20; i++) step(0, '0, 1, 0, 0, 0);
    step(0, '0, 0, 0, 0, 1);

    // Snapshot: writes before arm are dropped, then one capture to DONE
    for (int i = 0; i < 4; i++) step(1, DW'(16'h00A0 + i), 0, 1, 0, 0);
    idle(3, 1);
    step(0, '0, 0, 1, 1, 0);
    for (int i = 0; i < 20; i++) step(1, DW'(16'h0100 + i), 0, 1, 0, 0);
    idle(3, 1);
    chk("snapshot_done", int'(done), 1);
    for (int i = 0; i < 16; i++) step(0, '0, 1, 1, 0, 0);
    idle(2, 1);

    // Underflow, clear, and clear racing a new underflow
    step(0, '0, 1, 0, 0, 0);
    step(0, '0, 0, 0, 0, 1);
    step(0, '0, 1, 0, 0, 1);
    idle(2, 0);

    // Randomized traffic with occasional mode changes, arms and clears
    begin
      bit rm = 0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 59) == 0) rm = !rm;
        step($urandom_range(0, 9) < 6, DW'($urandom), $urandom_range(0, 9) < 4,
             rm, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
      end
    end
    idle(4, 0);
`ifndef FIFO_FWFT_EN
    chk("scoreboard_drained", exp_q.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
